// File: rtl/elem_packer.sv
// elem_packer: single-clock width-up converter placed after cdc_fifo on its output clock domain.
// It packs PACK_COUNT consecutive ELEM_WIDTH-bit elements into one wide word. The first
// accepted element goes in the LSBs. An accumulator plus a one-word output register sustain one
// element per cycle. A second word parks in the accumulator (HOLD) while the output is stalled.
//
// Optional feature: define ELEM_PACKER_LAST_EN to add elem_in_last_i. A "last" beat then
// flushes a partial word, and any unused upper lanes of that word are zero.
//
// Ports:
//   clk_i            clock (rising edge)
//   arst_ni          asynchronous active-low reset
//   elem_in_i        input element
//   elem_in_valid_i  input element valid
//   elem_in_ready_o  block can accept an element (low only while a word is held)
//   elem_in_last_i   element closes the burst (ELEM_PACKER_LAST_EN only)
//   word_out_o       packed word
//   word_count_o     number of valid elements in word_out_o
//   word_out_valid_o output word valid
//   word_out_ready_i consumer accepts the word
module elem_packer #(
   parameter int unsigned ELEM_WIDTH = 4,
   parameter int unsigned PACK_COUNT = 4
) (
   input  logic                               clk_i,
   input  logic                               arst_ni,
   input  logic [ELEM_WIDTH-1:0]              elem_in_i,
   input  logic                               elem_in_valid_i,
   output logic                               elem_in_ready_o,
`ifdef ELEM_PACKER_LAST_EN
   input  logic                               elem_in_last_i,
`endif
   output logic [PACK_COUNT*ELEM_WIDTH-1:0]   word_out_o,
   output logic [$clog2(PACK_COUNT+1)-1:0]    word_count_o,
   output logic                               word_out_valid_o,
   input  logic                               word_out_ready_i
);

   localparam int unsigned AW = $clog2(PACK_COUNT);
   localparam int unsigned CW = $clog2(PACK_COUNT + 1);
   localparam int unsigned WW = PACK_COUNT * ELEM_WIDTH;
   localparam logic [AW-1:0] LastLane = AW'(PACK_COUNT - 1);

   typedef enum logic {StFill, StHold} state_e;

   state_e          r_state;
   logic [WW-1:0]   r_acc_data;
   logic [AW-1:0]   r_acc_cnt;
   logic [CW-1:0]   r_hold_cnt;
   logic [WW-1:0]   r_out_data;
   logic [CW-1:0]   r_out_cnt;
   logic            r_out_valid;

   logic [WW-1:0]   w_merged;
   logic [CW-1:0]   w_count;
   logic            w_accept;
   logic            w_close;
   logic            w_slot_free;

   assign elem_in_ready_o  = (r_state == StFill);
   assign word_out_o       = r_out_data;
   assign word_count_o     = r_out_cnt;
   assign word_out_valid_o = r_out_valid;

   assign w_accept    = elem_in_valid_i && elem_in_ready_o;
   assign w_slot_free = !r_out_valid || word_out_ready_i;
   assign w_count     = CW'(r_acc_cnt) + CW'(1);

`ifdef ELEM_PACKER_LAST_EN
   assign w_close = (r_acc_cnt == LastLane) || elem_in_last_i;
`else
   assign w_close = (r_acc_cnt == LastLane);
`endif

   // Accumulator with the current element dropped into lane r_acc_cnt. Lanes above it are
   // still zero because the accumulator is cleared whenever a word leaves it.
   always_comb begin
      w_merged = r_acc_data;
      for (int unsigned i = 0; i < PACK_COUNT; i++) begin
         if (r_acc_cnt == AW'(i)) begin
            w_merged[i*ELEM_WIDTH +: ELEM_WIDTH] = elem_in_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state     <= StFill;
         r_acc_data  <= '0;
         r_acc_cnt   <= '0;
         r_hold_cnt  <= '0;
         r_out_data  <= '0;
         r_out_cnt   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         // A handshake frees the output. A load in the same cycle overrides this below.
         if (r_out_valid && word_out_ready_i) begin
            r_out_valid <= 1'b0;
         end
         unique case (r_state)
            StFill: begin
               if (w_accept) begin
                  if (w_close && w_slot_free) begin
                     r_out_data  <= w_merged;
                     r_out_cnt   <= w_count;
                     r_out_valid <= 1'b1;
                     r_acc_data  <= '0;
                     r_acc_cnt   <= '0;
                  end else if (w_close) begin
                     // Output busy: park the finished word and stall the input.
                     r_acc_data  <= w_merged;
                     r_hold_cnt  <= w_count;
                     r_state     <= StHold;
                  end else begin
                     r_acc_data  <= w_merged;
                     r_acc_cnt   <= r_acc_cnt + AW'(1);
                  end
               end
            end
            StHold: begin
               if (w_slot_free) begin
                  r_out_data  <= r_acc_data;
                  r_out_cnt   <= r_hold_cnt;
                  r_out_valid <= 1'b1;
                  r_acc_data  <= '0;
                  r_acc_cnt   <= '0;
                  r_state     <= StFill;
               end
            end
            default: r_state <= StFill;
         endcase
      end
   end

endmodule

// File: doc/elem_packer.md
# elem_packer

Single-clock width-up converter that sits directly downstream of `cdc_fifo` on its output clock domain. It consumes the FIFO's narrow element stream over a valid/ready handshake and packs `PACK_COUNT` consecutive elements into one wide word, which it emits over a second valid/ready handshake. A one-word output register plus a separate accumulator sustain one element per cycle and decouple output backpressure from input acceptance. An optional end-of-burst marker flushes partial words.

## Interface
- `ELEM_WIDTH`, default 4: bits per element; must match the upstream `cdc_fifo`.
- `PACK_COUNT`, default 4: elements per output word; must be ≥2.
- `clk_i` input, 1 bit: the single clock, i.e. the `cdc_fifo` output clock; rising edge.
- `arst_ni` input, 1 bit: reset, asynchronous assert, active-low.
- `elem_in_i` input, `ELEM_WIDTH` bits: input element.
- `elem_in_valid_i` input, 1 bit: input element valid.
- `elem_in_ready_o` output, 1 bit: the block can accept an element.
- `elem_in_last_i` input, 1 bit: the element closes the burst. Present only with `ELEM_PACKER_LAST_EN`.
- `word_out_o` output, `PACK_COUNT*ELEM_WIDTH` bits: packed word. The first-accepted element occupies the LSBs.
- `word_count_o` output, `$clog2(PACK_COUNT+1)` bits: number of valid elements in `word_out_o`.
- `word_out_valid_o` output, 1 bit: output word valid.
- `word_out_ready_i` input, 1 bit: the consumer accepts the word.

## Operation
- Internal state:
  - accumulator data register
  - `acc_cnt` (0..PACK_COUNT-1)
  - state `FILL`/`HOLD`
  - output register with valid flag
- `elem_in_ready_o = (state == FILL)`. It is purely registered-state based and has no combinational path from `word_out_ready_i`.
- Element accept happens when `elem_in_valid_i && elem_in_ready_o`:
  - The element is written to lane `acc_cnt`.
  - `acc_cnt` increments.
- A closing beat is an accepted element with `acc_cnt == PACK_COUNT-1`, or with `elem_in_last_i == 1` when the macro is enabled.
- Output slot free means `!word_out_valid_o || word_out_ready_i`.
- Closing beat while the slot is free:
  - The output register loads the accumulator contents merged with the current element.
  - `word_count_o` is set to `acc_cnt+1`.
  - `acc_cnt` goes to 0 and the state stays `FILL`.
- Closing beat while the slot is not free:
  - The merged word and count are held in the accumulator and the state moves to `HOLD`.
- In `HOLD`, the first cycle the slot is free transfers the held word to the output register, clears `acc_cnt` and moves to `FILL`.
- Lanes at index ≥ `word_count_o` in a partial word are zero.
- An output handshake `word_out_valid_o && word_out_ready_i` with no same-cycle load clears `word_out_valid_o`.
- `word_out_o` and `word_count_o` are stable while `word_out_valid_o` is high and `word_out_ready_i` is low.
- Once asserted, `word_out_valid_o` never drops without a handshake.
- With `elem_in_valid_i` low, nothing changes on the input side.
- `elem_in_i` and `elem_in_last_i` are ignored when not accepted.

## Timing
- Reset values:
  - `elem_in_ready_o` = 1
  - `word_out_valid_o` = 0
  - `word_out_o` = 0
  - `word_count_o` = 0
  - `acc_cnt` = 0
  - state = `FILL`
- Reset mid-operation discards the partial accumulator and any held or output word immediately (asynchronously). No word is emitted for the discarded data.
- Latency: a closing beat accepted at edge k while the slot is free gives `word_out_valid_o` = 1 after edge k.
- Throughput: one element per cycle sustained while the consumer holds ready high. A full word appears every `PACK_COUNT` cycles with no bubbles.
- Simultaneous output handshake and closing beat at the same edge:
  - The new word replaces the old one.
  - `word_out_valid_o` stays 1.
  - The state stays `FILL`.
- Storage and stall point: at most two words are stored (output register plus `HOLD`). Input stalls only in `HOLD`.
- Entering and leaving `HOLD`:
  - `elem_in_ready_o` deasserts the cycle after the beat that entered `HOLD`.
  - It reasserts the cycle after the transfer edge.

## Configuration
- `ELEM_PACKER_LAST_EN` defined:
  - The `elem_in_last_i` port exists.
  - Partial words are flushed on last, with `word_count_o` between 1 and `PACK_COUNT`.
  - A last on lane `PACK_COUNT-1` is an ordinary full word.
- `ELEM_PACKER_LAST_EN` undefined:
  - The port is absent.
  - Words close only when full.
  - `word_count_o` equals `PACK_COUNT` whenever `word_out_valid_o` is high.

## Test plan
All scenarios use ELEM_WIDTH=4, PACK_COUNT=4.
- Consumer ready held high, elements 1,2,3,4 on consecutive cycles → one word `0x4321`, count 4, valid exactly one cycle after the 4th accept. `elem_in_ready_o` never drops.
- With the macro defined: 0xA, then 0xB with last=1 → word `0x00BA`, count 2. The next 0xC starts at lane 0.
- Consumer ready held low, 16 elements offered back-to-back:
  - `elem_in_ready_o` drops after exactly 8 accepts.
  - Words `0x4321` and `0x8765` are held stable.
  - Raising ready yields them in order, with no loss or duplication.
- Word A valid, consumer ready=1 on the same edge that Word B's closing beat is accepted → A handshaken, B valid the next cycle, no `HOLD` entry.
- `arst_ni` pulsed low after 2 elements accepted and one word pending → all outputs at their reset values immediately. The next 4 elements produce a clean word, count 4.
- Randomised ready/valid for 10k elements, with `elem_in_valid_i` and `word_out_ready_i` each an independent random bit every cycle → output stream equals the input elements in order. Ready/valid stability holds at every cycle.
